// File: rtl/cordic_rotation.sv
// cordic_rotation: iterative rotation-mode CORDIC, one micro-rotation per clock.
// Rotates signed (x, y) by binary angle z (0x8000 = -pi); one transaction in flight.
// Optional macro CORDIC_GAIN_COMP_EN adds a SCALE state that removes the CORDIC
// gain (multiply by K = 0.6072529 in Q1.15); without it outputs carry the gain.
module cordic_rotation #(
  parameter int W    = 16,
  parameter int ITER = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      x_in,
  input  logic [W-1:0]      y_in,
  input  logic [15:0]       z_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W+1:0]      x_out,
  output logic [W+1:0]      y_out,
  output logic [15:0]       z_res
);

  localparam int WE = W + 2;

`ifdef CORDIC_GAIN_COMP_EN
  typedef enum logic [1:0] {IDLE, ROT, SCALE, DONE} state_e;
  localparam logic signed [15:0] GAIN_K = 16'sd19899;
`else
  typedef enum logic [1:0] {IDLE, ROT, DONE} state_e;
`endif

  state_e                 state_q, state_d;
  logic signed [WE-1:0]   x_q, x_d, y_q, y_d;
  logic        [15:0]     z_q, z_d;
  logic        [4:0]      iter_q, iter_d;
  logic                   out_valid_q, out_valid_d;
  logic        [WE-1:0]   x_out_q, x_out_d, y_out_q, y_out_d;
  logic        [15:0]     z_res_q, z_res_d;

  logic signed [WE-1:0]   x_ext, y_ext, x_shift, y_shift, x_rot, y_rot;
  logic        [15:0]     z_rot;
`ifdef CORDIC_GAIN_COMP_EN
  logic signed [WE+15:0]  x_prod, y_prod;
`endif

  // atan(2^-i) in units of pi/2^15, rounded
  function automatic logic [15:0] atan_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    atan_lut = 16'd8192;
      4'd1:    atan_lut = 16'd4836;
      4'd2:    atan_lut = 16'd2555;
      4'd3:    atan_lut = 16'd1297;
      4'd4:    atan_lut = 16'd651;
      4'd5:    atan_lut = 16'd326;
      4'd6:    atan_lut = 16'd163;
      4'd7:    atan_lut = 16'd81;
      4'd8:    atan_lut = 16'd41;
      4'd9:    atan_lut = 16'd20;
      4'd10:   atan_lut = 16'd10;
      4'd11:   atan_lut = 16'd5;
      4'd12:   atan_lut = 16'd3;
      4'd13:   atan_lut = 16'd1;
      4'd14:   atan_lut = 16'd1;
      default: atan_lut = 16'd0;
    endcase
  endfunction

  // Datapath: sign extension, one micro-rotation and optional gain scaling
  always_comb begin
    x_ext   = {{2{x_in[W-1]}}, x_in};
    y_ext   = {{2{y_in[W-1]}}, y_in};
    x_shift = x_q >>> iter_q;
    y_shift = y_q >>> iter_q;
    if (z_q[15]) begin
      x_rot = x_q + y_shift;
      y_rot = y_q - x_shift;
      z_rot = z_q + atan_lut(iter_q[3:0]);
    end else begin
      x_rot = x_q - y_shift;
      y_rot = y_q + x_shift;
      z_rot = z_q - atan_lut(iter_q[3:0]);
    end
`ifdef CORDIC_GAIN_COMP_EN
    x_prod = x_q * GAIN_K;
    y_prod = y_q * GAIN_K;
`endif
  end

  // Next-state and registered-output logic of the control FSM
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    iter_d      = iter_q;
    out_valid_d = out_valid_q;
    x_out_d     = x_out_q;
    y_out_d     = y_out_q;
    z_res_d     = z_res_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // |z| > pi/2: rotate by pi up front so the iterations only cover +-pi/2
          if (z_in[15] ^ z_in[14]) begin
            x_d = -x_ext;
            y_d = -y_ext;
            z_d = z_in + 16'h8000;
          end else begin
            x_d = x_ext;
            y_d = y_ext;
            z_d = z_in;
          end
          iter_d  = '0;
          state_d = ROT;
        end
      end
      ROT: begin
        x_d    = x_rot;
        y_d    = y_rot;
        z_d    = z_rot;
        iter_d = iter_q + 5'd1;
        if (iter_q == 5'(ITER - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_d = SCALE;
`else
          x_out_d     = x_rot;
          y_out_d     = y_rot;
          z_res_d     = z_rot;
          out_valid_d = 1'b1;
          state_d     = DONE;
`endif
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      SCALE: begin
        x_out_d     = x_prod[WE+14:15];
        y_out_d     = y_prod[WE+14:15];
        z_res_d     = z_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
`endif
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any transaction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      iter_q      <= '0;
      out_valid_q <= 1'b0;
      x_out_q     <= '0;
      y_out_q     <= '0;
      z_res_q     <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      iter_q      <= iter_d;
      out_valid_q <= out_valid_d;
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
      z_res_q     <= z_res_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign z_res     = z_res_q;

endmodule

// File: tb/tb_cordic_rotation.sv
// Directed self-checking bench for cordic_rotation (W=16, ITER=16).
module tb_cordic_rotation;
  localparam int W    = 16;
  localparam int ITER = 16;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT    = ITER + 1;
  localparam int PERIOD = ITER + 3;
  localparam int E_MAIN = 16384;
  localparam int E_EXX  = 32771;
  localparam int E_EXY  = 32765;
`else
  localparam int LAT    = ITER;
  localparam int PERIOD = ITER + 2;
  localparam int E_MAIN = 26981;
  localparam int E_EXX  = 53966;
  localparam int E_EXY  = 53956;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    x_in = '0;
  logic [W-1:0]    y_in = '0;
  logic [15:0]     z_in = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [W+1:0]    x_out;
  logic [W+1:0]    y_out;
  logic [15:0]     z_res;

  int n_cmp = 0;
  int n_bad = 0;

  cordic_rotation #(.W(W), .ITER(ITER)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .out_valid(out_valid),
    .out_ready(out_ready), .x_out(x_out), .y_out(y_out), .z_res(z_res)
  );

  always #5 clk = ~clk;

  // Drive one transaction; lat = edges from accept to out_valid, -1 on timeout
  task automatic send(input logic [15:0] xv, input logic [15:0] yv,
                      input logic [15:0] zv, output int lat);
    int w;
    @(negedge clk);
    x_in = xv; y_in = yv; z_in = zv; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 200);
    if (!out_valid) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (x_out !== '0 || y_out !== '0) begin n_bad++; $display("FAIL reset_xy got %h/%h want 0/0", x_out, y_out); end
    n_cmp++; if (z_res !== 16'h0) begin n_bad++; $display("FAIL reset_z_res got %h want 0000", z_res); end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_exit_out_ready got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_zero_angle();
    int lat, xo, yo;
    out_ready = 1'b1;
    send(16'd16384, 16'd0, 16'h0000, lat);
    xo = int'($signed(x_out)); yo = int'($signed(y_out));
    n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL zero_latency got %0d want %0d", lat, LAT); end
    n_cmp++; if (xo > E_MAIN + 3 || xo < E_MAIN - 3) begin n_bad++; $display("FAIL zero_x got %0d want %0d+-3", xo, E_MAIN); end
    n_cmp++; if (yo > 3 || yo < -3) begin n_bad++; $display("FAIL zero_y got %0d want 0+-3", yo); end
    n_cmp++; if (z_res !== 16'h0000) begin n_bad++; $display("FAIL zero_z_res got %h want 0000", z_res); end
  endtask

  task automatic test_quarter();
    int lat, xo, yo;
    out_ready = 1'b1;
    send(16'd16384, 16'd0, 16'h4000, lat);
    xo = int'($signed(x_out)); yo = int'($signed(y_out));
    n_cmp++; if (xo > 3 || xo < -3) begin n_bad++; $display("FAIL quarter_x got %0d want 0+-3", xo); end
    n_cmp++; if (yo > E_MAIN + 3 || yo < E_MAIN - 3) begin n_bad++; $display("FAIL quarter_y got %0d want %0d+-3", yo, E_MAIN); end
    n_cmp++; if (z_res !== 16'h0000) begin n_bad++; $display("FAIL quarter_z_res got %h want 0000", z_res); end
  endtask

  task automatic test_pi();
    int lat, xo, yo;
    out_ready = 1'b1;
    send(16'd16384, 16'd0, 16'h8000, lat);
    xo = int'($signed(x_out)); yo = int'($signed(y_out));
    n_cmp++; if (xo > -E_MAIN + 3 || xo < -E_MAIN - 3) begin n_bad++; $display("FAIL pi_x got %0d want %0d+-3", xo, -E_MAIN); end
    n_cmp++; if (yo > 3 || yo < -3) begin n_bad++; $display("FAIL pi_y got %0d want 0+-3", yo); end
  endtask

`ifdef CORDIC_GAIN_COMP_EN
  task automatic test_gain_comp();
    int lat, xo, yo;
    out_ready = 1'b1;
    send(16'd16384, 16'd0, 16'h2000, lat);
    xo = int'($signed(x_out)); yo = int'($signed(y_out));
    n_cmp++; if (lat !== ITER + 1) begin n_bad++; $display("FAIL gain_latency got %0d want %0d", lat, ITER + 1); end
    n_cmp++; if (xo > 11589 || xo < 11581) begin n_bad++; $display("FAIL gain_x got %0d want 11585+-4", xo); end
    n_cmp++; if (yo > 11589 || yo < 11581) begin n_bad++; $display("FAIL gain_y got %0d want 11585+-4", yo); end
  endtask
`endif

  task automatic test_extremes();
    int lat, xo, yo;
    out_ready = 1'b1;
    send(16'h8000, 16'h8000, 16'h7FFF, lat);
    xo = int'($signed(x_out)); yo = int'($signed(y_out));
    n_cmp++; if (xo > E_EXX + 4 || xo < E_EXX - 4) begin n_bad++; $display("FAIL extreme_x got %0d want %0d+-4", xo, E_EXX); end
    n_cmp++; if (yo > E_EXY + 4 || yo < E_EXY - 4) begin n_bad++; $display("FAIL extreme_y got %0d want %0d+-4", yo, E_EXY); end
    n_cmp++; if (z_res !== 16'hFFFF) begin n_bad++; $display("FAIL extreme_z_res got %h want ffff", z_res); end
  endtask

  task automatic test_backpressure();
    int lat, w, xo;
    logic [W+1:0] sx, sy;
    logic [15:0]  sz;
    logic         stable_ok;
    out_ready = 1'b0;
    send(16'd16384, 16'd0, 16'h4000, lat);
    sx = x_out; sy = y_out; sz = z_res;
    x_in = 16'd16384; y_in = 16'd0; z_in = 16'h0000; in_valid = 1'b1;
    stable_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid !== 1'b1 || x_out !== sx || y_out !== sy || z_res !== sz || in_ready !== 1'b0)
        stable_ok = 1'b0;
    end
    n_cmp++; if (stable_ok !== 1'b1) begin n_bad++; $display("FAIL bp_hold got v=%b x=%h in_ready=%b want v=1 x=%h in_ready=0", out_valid, x_out, in_ready, sx); end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_taken_out_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_idle_in_ready got %b want 1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_second_accept got in_ready %b want 0", in_ready); end
    w = 0;
    while (!out_valid && w < 200) begin
      @(negedge clk);
      w++;
    end
    xo = int'($signed(x_out));
    n_cmp++; if (xo > E_MAIN + 3 || xo < E_MAIN - 3) begin n_bad++; $display("FAIL bp_second_x got %0d want %0d+-3", xo, E_MAIN); end
  endtask

  task automatic test_back_to_back();
    int e, a0, a1;
    out_ready = 1'b1;
    @(negedge clk);
    x_in = 16'd16384; y_in = 16'd0; z_in = 16'h4000; in_valid = 1'b1;
    e = 0; a0 = -1; a1 = -1;
    while (a1 < 0 && e < 200) begin
      if (in_ready) begin
        if (a0 < 0) a0 = e;
        else a1 = e;
      end
      @(posedge clk);
      e++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_cmp++; if (a1 - a0 !== PERIOD) begin n_bad++; $display("FAIL b2b_period got %0d want %0d", a1 - a0, PERIOD); end
    repeat (PERIOD + 4) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    int lat, xo;
    out_ready = 1'b1;
    @(negedge clk);
    x_in = 16'd16384; y_in = 16'd0; z_in = 16'h0000; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
    n_cmp++; if (x_out !== '0 || y_out !== '0) begin n_bad++; $display("FAIL rstmid_xy got %h/%h want 0/0", x_out, y_out); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send(16'd16384, 16'd0, 16'h0000, lat);
    xo = int'($signed(x_out));
    n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL rstmid_latency got %0d want %0d", lat, LAT); end
    n_cmp++; if (xo > E_MAIN + 3 || xo < E_MAIN - 3) begin n_bad++; $display("FAIL rstmid_x got %0d want %0d+-3", xo, E_MAIN); end
  endtask

  initial begin
    test_reset();
    test_zero_angle();
    test_quarter();
    test_pi();
`ifdef CORDIC_GAIN_COMP_EN
    test_gain_comp();
`endif
    test_extremes();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
